// File: rtl/ibuf_flex_pkg.sv
// ibuf_flex_pkg: shared defaults and helpers for the instruction buffer slice.
package ibuf_flex_pkg;
    localparam int FETCH_WIDTH_DEFAULT  = 4;
    localparam int DECODE_WIDTH_DEFAULT = 4;
    localparam int IBUF_DEPTH_DEFAULT   = 32;
    localparam int ILEN_DEFAULT         = 32;
    localparam int PLEN_DEFAULT         = 32;
    localparam int META_W_DEFAULT       = 8;

    function automatic int pc_step(int ilen);
        return ilen / 8;
    endfunction
endpackage

// File: rtl/ibuf_flex_if.sv
// ibuf_flex_if: fetch-side and decode-side handshake bundle of the instruction buffer.
interface ibuf_flex_if
    import ibuf_flex_pkg::*;
#(
    parameter int FETCH_WIDTH  = FETCH_WIDTH_DEFAULT,
    parameter int DECODE_WIDTH = DECODE_WIDTH_DEFAULT,
    parameter int ILEN         = ILEN_DEFAULT,
    parameter int PLEN         = PLEN_DEFAULT,
    parameter int META_W       = META_W_DEFAULT
);
    logic                                 fe_valid;
    logic                                 fe_ready;
    logic [FETCH_WIDTH-1:0]               fe_mask;
    logic [FETCH_WIDTH*ILEN-1:0]          fe_instrs;
    logic [PLEN-1:0]                      fe_pc;
    logic [FETCH_WIDTH*META_W-1:0]        fe_meta;
    logic [DECODE_WIDTH-1:0]              ibuf_valid;
    logic [DECODE_WIDTH*ILEN-1:0]         ibuf_instrs;
    logic [DECODE_WIDTH*PLEN-1:0]         ibuf_pcs;
    logic [DECODE_WIDTH*META_W-1:0]       ibuf_meta;
    logic [$clog2(DECODE_WIDTH+1)-1:0]    ibuf_deq_cnt;

    modport master (
        output fe_valid, fe_mask, fe_instrs, fe_pc, fe_meta, ibuf_deq_cnt,
        input  fe_ready, ibuf_valid, ibuf_instrs, ibuf_pcs, ibuf_meta
    );
    modport slave (
        input  fe_valid, fe_mask, fe_instrs, fe_pc, fe_meta, ibuf_deq_cnt,
        output fe_ready, ibuf_valid, ibuf_instrs, ibuf_pcs, ibuf_meta
    );
endinterface

// File: rtl/ibuf_flex_compact.sv
// ibuf_compact: packs the set slots of a fetch group into consecutive lanes, in slot order,
// and computes each surviving instruction's PC from its original slot index.
module ibuf_compact
    import ibuf_flex_pkg::*;
#(
    parameter int FETCH_WIDTH = FETCH_WIDTH_DEFAULT,
    parameter int ILEN        = ILEN_DEFAULT,
    parameter int PLEN        = PLEN_DEFAULT,
    parameter int META_W      = META_W_DEFAULT
) (
    input  logic [FETCH_WIDTH-1:0]             mask,
    input  logic [FETCH_WIDTH*ILEN-1:0]        instrs,
    input  logic [FETCH_WIDTH*META_W-1:0]      meta,
    input  logic [PLEN-1:0]                    pc,
    output logic [FETCH_WIDTH*ILEN-1:0]        c_instrs,
    output logic [FETCH_WIDTH*PLEN-1:0]        c_pcs,
    output logic [FETCH_WIDTH*META_W-1:0]      c_meta,
    output logic [$clog2(FETCH_WIDTH+1)-1:0]   push_n
);
    // push_n doubles as the running prefix popcount: it is the destination lane of slot i
    always_comb begin
        c_instrs = '0;
        c_pcs    = '0;
        c_meta   = '0;
        push_n   = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (mask[i]) begin
                c_instrs[push_n*ILEN +: ILEN]     = instrs[i*ILEN +: ILEN];
                c_meta[push_n*META_W +: META_W]   = meta[i*META_W +: META_W];
                c_pcs[push_n*PLEN +: PLEN]        = pc + PLEN'(i * pc_step(ILEN));
                push_n = push_n + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ibuf_flex.sv
// ibuf_flex: circular instruction buffer between fetch and decode with masked
// compacting enqueue and variable-width in-order dequeue.
module ibuf_flex
    import ibuf_flex_pkg::*;
#(
    parameter int FETCH_WIDTH  = FETCH_WIDTH_DEFAULT,
    parameter int DECODE_WIDTH = DECODE_WIDTH_DEFAULT,
    parameter int IB_DEPTH     = IBUF_DEPTH_DEFAULT,
    parameter int ILEN         = ILEN_DEFAULT,
    parameter int PLEN         = PLEN_DEFAULT,
    parameter int META_W       = META_W_DEFAULT
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    ibuf_flex_if.slave                     bus,
    output logic [$clog2(IB_DEPTH+1)-1:0]  count_o
);
    localparam int AW  = $clog2(IB_DEPTH);
    localparam int CW  = $clog2(IB_DEPTH + 1);
    localparam int DCW = $clog2(DECODE_WIDTH + 1);
    localparam int FCW = $clog2(FETCH_WIDTH + 1);

    if (IB_DEPTH < FETCH_WIDTH || (IB_DEPTH & (IB_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "ibuf_flex: IB_DEPTH must be a power of two and >= FETCH_WIDTH");
    end

    typedef struct packed {
        logic [ILEN-1:0]   instr;
        logic [PLEN-1:0]   pc;
        logic [META_W-1:0] meta;
    } entry_t;

    entry_t                      mem_q [IB_DEPTH];
    logic [AW-1:0]               rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]               count_q, count_d;
    logic [FETCH_WIDTH*ILEN-1:0] c_instrs;
    logic [FETCH_WIDTH*PLEN-1:0] c_pcs;
    logic [FETCH_WIDTH*META_W-1:0] c_meta;
    logic [FCW-1:0]              push_n;
    logic [DCW-1:0]              avail, pop_n;
    logic                        push;

    ibuf_compact #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .ILEN        (ILEN),
        .PLEN        (PLEN),
        .META_W      (META_W)
    ) u_compact (
        .mask     (bus.fe_mask),
        .instrs   (bus.fe_instrs),
        .meta     (bus.fe_meta),
        .pc       (bus.fe_pc),
        .c_instrs (c_instrs),
        .c_pcs    (c_pcs),
        .c_meta   (c_meta),
        .push_n   (push_n)
    );

    // ready only looks at occupancy so the mask never feeds back into the handshake
    assign bus.fe_ready = !flush_i && (count_q <= CW'(IB_DEPTH - FETCH_WIDTH));
    assign push         = bus.fe_valid && bus.fe_ready;
    assign avail        = (count_q >= CW'(DECODE_WIDTH)) ? DCW'(DECODE_WIDTH) : DCW'(count_q);
    assign pop_n        = flush_i ? '0 : (bus.ibuf_deq_cnt > avail ? avail : bus.ibuf_deq_cnt);
    assign count_d      = flush_i ? '0 : count_q + (push ? CW'(push_n) : '0) - CW'(pop_n);
    assign count_o      = count_q;

    always_comb begin
        bus.ibuf_valid  = '0;
        bus.ibuf_instrs = '0;
        bus.ibuf_pcs    = '0;
        bus.ibuf_meta   = '0;
        for (int j = 0; j < DECODE_WIDTH; j++) begin
            bus.ibuf_valid[j]                 = !flush_i && (count_q > CW'(j));
            bus.ibuf_instrs[j*ILEN +: ILEN]   = mem_q[rd_ptr_q + AW'(j)].instr;
            bus.ibuf_pcs[j*PLEN +: PLEN]      = mem_q[rd_ptr_q + AW'(j)].pc;
            bus.ibuf_meta[j*META_W +: META_W] = mem_q[rd_ptr_q + AW'(j)].meta;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < IB_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= flush_i ? '0 : rd_ptr_q + AW'(pop_n);
            wr_ptr_q <= flush_i ? '0 : (push ? wr_ptr_q + AW'(push_n) : wr_ptr_q);
            if (push) begin
                for (int k = 0; k < FETCH_WIDTH; k++) begin
                    if (FCW'(k) < push_n)
                        mem_q[wr_ptr_q + AW'(k)] <= '{instr: c_instrs[k*ILEN +: ILEN],
                                                      pc:    c_pcs[k*PLEN +: PLEN],
                                                      meta:  c_meta[k*META_W +: META_W]};
                end
            end
        end
    end

    // over-asking decode is clamped in hardware; flag it in simulation
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i)
            assert (bus.ibuf_deq_cnt <= avail)
            else $warning("ibuf_flex: dequeue request %0d exceeds %0d presented entries",
                          bus.ibuf_deq_cnt, avail);
    end
endmodule

// File: doc/ibuf_flex.md
Name: ibuf_flex

Overview:
Parametrised instruction buffer between the fetch frontend and decode.
- Accepts fetch groups with a per-slot valid mask; only set slots are enqueued, compacted in slot order.
- Presents up to DECODE_WIDTH entries per cycle with per-slot valid and variable dequeue count, so decode can consume partial bundles.
- Carries per-instruction metadata (e.g. branch prediction, fetch fault bits) alongside instr/PC.

Parameters:
FETCH_WIDTH, 4, instruction slots per fetch group
DECODE_WIDTH, 4, max entries presented/dequeued per cycle
IB_DEPTH, 32, entry count; power of two, >= FETCH_WIDTH; elaboration $fatal otherwise
ILEN, 32, instruction width; PC step per slot = ILEN/8
PLEN, 32, PC width
META_W, 8, per-instruction metadata width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  drop all contents this cycle
fe_valid_i  in  1  fetch group valid
fe_ready_o  out  1  buffer can accept a full group
fe_mask_i  in  FETCH_WIDTH  per-slot valid; arbitrary pattern
fe_instrs_i  in  FETCH_WIDTH*ILEN  group instructions
fe_pc_i  in  PLEN  PC of slot 0
fe_meta_i  in  FETCH_WIDTH*META_W  per-slot metadata
ibuf_valid_o  out  DECODE_WIDTH  per-slot valid, thermometer (slot j valid implies j-1 valid)
ibuf_instrs_o  out  DECODE_WIDTH*ILEN  oldest entries, slot 0 oldest
ibuf_pcs_o  out  DECODE_WIDTH*PLEN  PCs of presented entries
ibuf_meta_o  out  DECODE_WIDTH*META_W  metadata of presented entries
ibuf_deq_cnt_i  in  $clog2(DECODE_WIDTH+1)  entries decode consumes this cycle
count_o  out  $clog2(IB_DEPTH+1)  current occupancy (count_q)

Behaviour:
- Reset (async, rst_ni=0): rd_ptr, wr_ptr, count = 0; storage cleared to 0. Outputs: fe_ready_o=1 (when flush_i=0), ibuf_valid_o=0, data outputs 0, count_o=0.
- fe_ready_o = !flush_i && (IB_DEPTH - count_q >= FETCH_WIDTH). It does not depend on fe_mask_i, so there is no mask-to-ready path.
- Push when fe_valid_i && fe_ready_o:
  - push_n = popcount(fe_mask_i).
  - The k-th set slot (original index i) is written at wr_ptr_q+k mod IB_DEPTH with instr[i], pc = fe_pc_i + i*(ILEN/8), meta[i].
  - mask==0 is accepted as a no-op.
- Presentation is combinational from registered state:
  - ibuf_valid_o[j] = !flush_i && (j < count_q).
  - Slot j reads entry at rd_ptr_q+j mod IB_DEPTH.
  - Invalid slots show don't-care data.
  - No bypass: pushed entries are visible the cycle after push (latency 1).
- Pop: pop_n = min(ibuf_deq_cnt_i, popcount(ibuf_valid_o)).
  - A request exceeding the valid count is a protocol violation: a simulation assertion fires and RTL clamps.
  - rd_ptr_d = rd_ptr_q + pop_n.
- Simultaneous push/pop: count_d = count_q + push_n - pop_n. This is legal at full (push is blocked by ready) and at empty (pop_n=0).
- Flush has priority: pointers and count go to 0 next cycle; push and pop that cycle are ignored; storage is untouched.
- Wrap-around: pointers are $clog2(IB_DEPTH) bits and wrap naturally. count has one extra bit, so full (count=IB_DEPTH) and empty are distinguished.
- Storage is written only at the indices targeted by the push, not rewritten wholesale.

Decomposition:
- Shared package (global_config_pkg):
  - ibuf_flex entry fields: instr, pc, meta as a struct parametrised by the module widths, or declared locally if package widths are fixed.
  - Default IBUF depth constant.
- Sub-module ibuf_compact (combinational):
  - Inputs: mask, instrs, meta, base PC.
  - Outputs: compacted slot data, computed PCs, push_n.
  - Prefix-popcount selection network.
- Top level holds pointers, counters, storage and read mux.

Test Plan:
- Reset then push mask=4'b1111, PC=0x8000_0000, deq_cnt=0 -> next cycle ibuf_valid_o=4'b1111, pcs 0x8000_0000/04/08/0C, count_o=4.
- Push mask=4'b1010, instrs A,B,C,D, PC=0x100 -> slots 0,1 hold B@0x104, D@0x10C; ibuf_valid_o=4'b0011; count_o=2.
- Fill to 28 with deq_cnt=0 -> fe_ready_o=1; push one more group -> count_o=32, fe_ready_o=0. Next, deq_cnt=3 with fe_valid_i held -> count_o=29, fe_ready_o stays 0 until count<=28.
- Steady state: full-mask push and deq_cnt=2 every cycle, run past wrap -> count grows by 2/cycle until ready drops; PCs contiguous with no loss or duplication across the wrap.
- count_o=3 with deq_cnt=4 -> assertion fires, count_o=0, rd_ptr advances by 3.
- flush_i with a concurrent push and deq -> ibuf_valid_o=0 and fe_ready_o=0 that cycle; next cycle count_o=0. Assert rst_ni mid-stream -> same empty state immediately (asynchronously).
